// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder and its block former.
package sha256_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam int           SHA256_BLOCK_BYTES = 64;
    localparam int           SHA256_LEN_OFS     = 56;
    localparam logic [7:0]   SHA256_PAD_BYTE    = 8'h80;

    // Extra block still owed after the last data block has been emitted
    typedef enum logic [1:0] {
        NONE     = 2'd0,
        LEN_ONLY = 2'd1,
        PAD_LEN  = 2'd2
    } tail_t;

    typedef enum logic {
        S_FILL = 1'b0,
        S_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/sha256_pad_fmt.sv
// Combinational block former: message bytes below n, optional 0x80 at n, zero fill,
// optional 64-bit big-endian length in bytes 56..63.
module sha256_pad_fmt
    import sha256_pkg::*;
(
    input  logic [511:0] msg,
    input  logic [6:0]   n,
    input  logic         pad_en,
    input  logic         len_en,
    input  logic [63:0]  bitlen,
    output logic [511:0] block
);

    // Select each output byte from length, message, pad marker or zero
    always_comb begin
        block = 512'd0;
        for (int i = 0; i < SHA256_BLOCK_BYTES; i++) begin
            if (len_en && (i >= SHA256_LEN_OFS)) begin
                block[511-8*i -: 8] = bitlen[8*(63-i) +: 8];
            end else if (7'(i) < n) begin
                block[511-8*i -: 8] = msg[511-8*i -: 8];
            end else if (pad_en && (7'(i) == n)) begin
                block[511-8*i -: 8] = SHA256_PAD_BYTE;
            end else begin
                block[511-8*i -: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects bytes, appends padding and length, emits 512-bit blocks.
// Optional SHA256_PADDER_STATS_EN adds a 32-bit transferred-block counter output.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
`ifdef SHA256_PADDER_STATS_EN
    ,
    output logic [31:0]  blk_count
`endif
);

    state_t             state_r;
    tail_t              tail_r;
    logic [6:0]         datalen_r;
    logic [LEN_W-1:0]   bitlen_r;
    logic               first_pend_r;
    logic [511:0]       msg_buf_r;

    logic               accept_s;
    logic               xfer_s;
    logic               has_byte_s;
    logic [6:0]         n_s;
    logic [LEN_W-1:0]   bitlen_next_s;
    logic [511:0]       buf_next_s;
    logic [511:0]       fmt_msg_s;
    logic [6:0]         fmt_n_s;
    logic               fmt_pad_s;
    logic               fmt_len_s;
    logic [63:0]        fmt_bitlen_s;
    logic [511:0]       fmt_block_s;

    assign accept_s   = in_valid & in_ready;
    assign xfer_s     = blk_valid & blk_ready;
    assign has_byte_s = ~(in_last & in_empty);

    // Buffer, byte count and bit length as they stand after the current beat
    always_comb begin
        buf_next_s = msg_buf_r;
        for (int i = 0; i < SHA256_BLOCK_BYTES; i++) begin
            if (has_byte_s && (datalen_r == 7'(i))) begin
                buf_next_s[511-8*i -: 8] = in_data;
            end else begin
                buf_next_s[511-8*i -: 8] = msg_buf_r[511-8*i -: 8];
            end
        end
        if (has_byte_s) begin
            n_s           = datalen_r + 7'd1;
            bitlen_next_s = bitlen_r + LEN_W'(4'd8);
        end else begin
            n_s           = datalen_r;
            bitlen_next_s = bitlen_r;
        end
    end

    // Filling forms the block around the incoming beat; emitting forms the owed tail block
    always_comb begin
        if (state_r == S_FILL) begin
            fmt_msg_s    = buf_next_s;
            fmt_n_s      = n_s;
            fmt_pad_s    = in_last && (n_s <= 7'd63);
            fmt_len_s    = in_last && (n_s <= 7'd55);
            fmt_bitlen_s = 64'(bitlen_next_s);
        end else begin
            fmt_msg_s    = msg_buf_r;
            fmt_n_s      = 7'd0;
            fmt_pad_s    = (tail_r == PAD_LEN);
            fmt_len_s    = 1'b1;
            fmt_bitlen_s = 64'(bitlen_r);
        end
    end

    sha256_pad_fmt u_fmt (
        .msg    (fmt_msg_s),
        .n      (fmt_n_s),
        .pad_en (fmt_pad_s),
        .len_en (fmt_len_s),
        .bitlen (fmt_bitlen_s),
        .block  (fmt_block_s)
    );

    // Fill/emit control with registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_FILL;
            tail_r       <= NONE;
            datalen_r    <= 7'd0;
            bitlen_r     <= '0;
            first_pend_r <= 1'b1;
            msg_buf_r    <= 512'd0;
            in_ready     <= 1'b0;
            blk_valid    <= 1'b0;
            blk_data     <= 512'd0;
            blk_first    <= 1'b0;
            blk_last     <= 1'b0;
        end else begin
            case (state_r)
                S_FILL: begin
                    in_ready <= 1'b1;
                    if (accept_s) begin
                        msg_buf_r <= buf_next_s;
                        datalen_r <= n_s;
                        bitlen_r  <= bitlen_next_s;
                        if (in_last || (n_s == 7'd64)) begin
                            state_r   <= S_EMIT;
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            blk_data  <= fmt_block_s;
                            blk_first <= first_pend_r;
                            if (!in_last) begin
                                blk_last <= 1'b0;
                                tail_r   <= NONE;
                            end else if (n_s <= 7'd55) begin
                                blk_last <= 1'b1;
                                tail_r   <= NONE;
                            end else if (n_s <= 7'd63) begin
                                blk_last <= 1'b0;
                                tail_r   <= LEN_ONLY;
                            end else begin
                                blk_last <= 1'b0;
                                tail_r   <= PAD_LEN;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    if (xfer_s) begin
                        first_pend_r <= 1'b0;
                        if (tail_r != NONE) begin
                            blk_data  <= fmt_block_s;
                            blk_first <= 1'b0;
                            blk_last  <= 1'b1;
                            tail_r    <= NONE;
                        end else begin
                            if (blk_last) begin
                                bitlen_r     <= '0;
                                first_pend_r <= 1'b1;
                            end
                            datalen_r <= 7'd0;
                            state_r   <= S_FILL;
                            in_ready  <= 1'b1;
                            blk_valid <= 1'b0;
                            blk_first <= 1'b0;
                            blk_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r   <= S_FILL;
                    tail_r    <= NONE;
                    datalen_r <= 7'd0;
                    in_ready  <= 1'b0;
                    blk_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHA256_PADDER_STATS_EN
    // Transferred-block counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_count <= 32'd0;
        end else if (xfer_s) begin
            blk_count <= blk_count + 32'd1;
        end else begin
            blk_count <= blk_count;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder against a queue-based FIPS 180-4 padding model.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_empty;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
`ifdef SHA256_PADDER_STATS_EN
    logic [31:0]  blk_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;

    logic [7:0]   msg_q[$];
    logic [511:0] exp_q[$];
    logic [511:0] first_blk;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'd0, 64'h18};

    sha256_padder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
`ifdef SHA256_PADDER_STATS_EN
        ,
        .blk_count (blk_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: message || 0x80 || zeros to 56 mod 64 || 64-bit bit length, cut into blocks
    function automatic void build_exp();
        logic [7:0]   q[$];
        logic [63:0]  bl;
        logic [511:0] b;
        q = msg_q;
        q.push_back(8'h80);
        while ((q.size() % 64) != 56) q.push_back(8'h00);
        bl = 64'(msg_q.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) q.push_back(bl[8*k +: 8]);
        exp_q.delete();
        for (int bi = 0; bi < q.size() / 64; bi++) begin
            b = 512'd0;
            for (int j = 0; j < 64; j++) b = {b[503:0], q[bi*64 + j]};
            exp_q.push_back(b);
        end
    endfunction

    task automatic run_msg(input bit stall, input bit gaps);
        int idx = 0;
        int blk = 0;
        int cyc = 0;
        int stall_n = 0;
        bit empty_sent = 1'b0;
        int len = msg_q.size();
        build_exp();
        while ((blk < exp_q.size()) && (cyc < 4000)) begin
            @(negedge clk);
            cyc++;
            if (blk_valid) begin
                in_valid = 1'b0;
                check("blk_data", blk_data, exp_q[blk]);
                check("blk_first", 512'(blk_first), 512'(blk == 0));
                check("blk_last", 512'(blk_last), 512'(blk == exp_q.size() - 1));
                check("in_ready_emit", 512'(in_ready), 512'd0);
                if (blk == 0) first_blk = blk_data;
                if (stall && (stall_n < 5)) begin
                    blk_ready = 1'b0;
                    stall_n++;
                end else begin
                    blk_ready = 1'b1;
                    blk++;
                end
            end else begin
                blk_ready = 1'b0;
                if (in_ready && ((idx < len) || ((len == 0) && !empty_sent))
                    && !(gaps && ($urandom_range(0, 3) == 0))) begin
                    in_valid = 1'b1;
                    if (len == 0) begin
                        in_data    = 8'h00;
                        in_last    = 1'b1;
                        in_empty   = 1'b1;
                        empty_sent = 1'b1;
                    end else begin
                        in_data  = msg_q[idx];
                        in_last  = (idx == len - 1);
                        in_empty = 1'b0;
                        idx++;
                    end
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("block_count_timeout", 512'(blk), 512'(exp_q.size()));
        exp_count += exp_q.size();
        @(negedge clk);
        blk_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_empty  = 1'b0;
        check("idle_blk_valid", 512'(blk_valid), 512'd0);
        check("idle_in_ready", 512'(in_ready), 512'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        in_empty = 1'b0; blk_ready = 1'b0; first_blk = 512'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_blk_valid", 512'(blk_valid), 512'd0);
        check("rst_in_ready", 512'(in_ready), 512'd0);
        check("rst_blk_first", 512'(blk_first), 512'd0);
        check("rst_blk_last", 512'(blk_last), 512'd0);
        check("rst_blk_data", blk_data, 512'd0);
`ifdef SHA256_PADDER_STATS_EN
        check("rst_blk_count", 512'(blk_count), 512'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 512'(in_ready), 512'd1);

        // "abc"
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(1'b0, 1'b0);
        check("abc_const", first_blk, ABC_BLK);

        // empty message
        msg_q.delete();
        run_msg(1'b0, 1'b0);
        check("empty_const", first_blk, {8'h80, 504'd0});

        // 55 / 56 zero bytes: boundary of the length fitting in the same block
        msg_q.delete();
        for (int i = 0; i < 55; i++) msg_q.push_back(8'h00);
        run_msg(1'b0, 1'b0);
        check("len55_count", 512'(exp_q.size()), 512'd1);
        msg_q.push_back(8'h00);
        run_msg(1'b0, 1'b0);
        check("len56_count", 512'(exp_q.size()), 512'd2);

        // 64 x 0x61 with the first block held off by backpressure
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'h61);
        run_msg(1'b1, 1'b0);

        // random messages across block boundaries, with input bubbles
        for (int m = 0; m < 6; m++) begin
            msg_q.delete();
            for (int i = 0; i < int'($urandom_range(0, 140)); i++) msg_q.push_back(8'($urandom));
            run_msg(m[0], 1'b1);
        end

        // reset mid-message after 30 bytes discards everything
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0; in_empty = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_count = 0;
        @(negedge clk);
        check("midrst_blk_valid", 512'(blk_valid), 512'd0);
        check("midrst_in_ready", 512'(in_ready), 512'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_release_in_ready", 512'(in_ready), 512'd1);
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(1'b0, 1'b0);
        check("abc_after_rst", first_blk, ABC_BLK);
`ifdef SHA256_PADDER_STATS_EN
        check("blk_count", 512'(blk_count), 512'(exp_count));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
